huffman_dec: RTL

HUFFMAN_DEC -- requirements
Module: huffman_dec

---
 rtl/huffman_dec.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/huffman_dec.sv
// Serial prefix-code decoder: six programmable codewords of 1..5 bits, MSB-first
// bit stream, one registered symbol or decode-error pulse per completed code.
module huffman_dec (
  input  logic       clk,
  input  logic       reset,
  input  logic       table_valid,
  input  logic [7:0] HC1,
  input  logic [7:0] HC2,
  input  logic [7:0] HC3,
  input  logic [7:0] HC4,
  input  logic [7:0] HC5,
  input  logic [7:0] HC6,
  input  logic [7:0] M1,
  input  logic [7:0] M2,
  input  logic [7:0] M3,
  input  logic [7:0] M4,
  input  logic [7:0] M5,
  input  logic [7:0] M6,
  input  logic       bit_valid,
  input  logic       bit_in,
  output logic       sym_valid,
  output logic [2:0] sym_out,
  output logic       dec_err,
  output logic       tbl_err,
  output logic       ready,
  output logic [7:0] sym_cnt
);

  typedef enum logic {NOTBL, RUN} state_t;

  state_t     state, state_nxt;
  logic [7:0] hc_in [6];
  logic [7:0] m_in  [6];
  logic [7:0] hc_q  [6];
  logic [7:0] m_q   [6];
  logic [4:0] acc_q, acc_nxt;
  logic [2:0] n_q, n_nxt;
  logic       tbl_ok;
  logic       accept;
  logic       hit;
  logic [2:0] hit_sym;

  assign hc_in[0] = HC1;
  assign hc_in[1] = HC2;
  assign hc_in[2] = HC3;
  assign hc_in[3] = HC4;
  assign hc_in[4] = HC5;
  assign hc_in[5] = HC6;
  assign m_in[0]  = M1;
  assign m_in[1]  = M2;
  assign m_in[2]  = M3;
  assign m_in[3]  = M4;
  assign m_in[4]  = M5;
  assign m_in[5]  = M6;

  function automatic logic mask_ok(input logic [7:0] m);
    return m inside {8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F};
  endfunction

  function automatic logic [2:0] mask_len(input logic [7:0] m);
    case (m)
      8'h01:   return 3'd1;
      8'h03:   return 3'd2;
      8'h07:   return 3'd3;
      8'h0F:   return 3'd4;
      8'h1F:   return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

  always_comb begin
    tbl_ok = 1'b1;
    for (int unsigned i = 0; i < 6; i++)
      if (!mask_ok(m_in[i])) tbl_ok = 1'b0;
  end

  assign accept = (state == RUN) && bit_valid && !table_valid;

  // Accumulator bits above n are always zero, so masking both sides is exact.
  always_comb begin
    acc_nxt = {acc_q[3:0], bit_in};
    n_nxt   = n_q + 3'd1;
    hit     = 1'b0;
    hit_sym = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      if (!hit && mask_len(m_q[i]) == n_nxt &&
          ((hc_q[i] ^ {3'b000, acc_nxt}) & m_q[i]) == 8'h00) begin
        hit     = 1'b1;
        hit_sym = 3'(i + 1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= NOTBL;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (table_valid) state_nxt = tbl_ok ? RUN : NOTBL;
  end

  always_comb begin
    ready = (state == RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 6; i++) begin
        hc_q[i] <= '0;
        m_q[i]  <= '0;
      end
      acc_q     <= '0;
      n_q       <= '0;
      sym_valid <= 1'b0;
      sym_out   <= '0;
      dec_err   <= 1'b0;
      tbl_err   <= 1'b0;
      sym_cnt   <= '0;
    end else begin
      sym_valid <= 1'b0;
      sym_out   <= '0;
      dec_err   <= 1'b0;
      if (table_valid) begin
        for (int unsigned i = 0; i < 6; i++) begin
          hc_q[i] <= hc_in[i];
          m_q[i]  <= m_in[i];
        end
        acc_q   <= '0;
        n_q     <= '0;
        sym_cnt <= '0;
        tbl_err <= !tbl_ok;
      end else if (accept) begin
        if (hit) begin
          sym_valid <= 1'b1;
          sym_out   <= hit_sym;
          acc_q     <= '0;
          n_q       <= '0;
          if (sym_cnt != 8'hFF) sym_cnt <= sym_cnt + 8'd1;
        end else if (n_nxt == 3'd5) begin
          dec_err <= 1'b1;
          acc_q   <= '0;
          n_q     <= '0;
        end else begin
          acc_q <= acc_nxt;
          n_q   <= n_nxt;
        end
      end
    end
  end

endmodule
